// File: rtl/regarb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - Architectural register numbers that get special treatment
//     ($0, $26/$27 kernel registers, $31 return address).
//   - State encoding for the starvation guard FSM.
//   - Source IDs naming which general writer won the port in a cycle.
//   - is_protected(): true for destinations whose writes are silently dropped.
package regarb_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_K0   = 5'd26;
   localparam logic [4:0] REG_K1   = 5'd27;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic {
      ST_NORMAL,
      ST_FORCE_ALU
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_MEM
   } src_t;

   function automatic logic is_protected(input logic [4:0] addr);
      return (addr == REG_ZERO) || (addr == REG_K0) || (addr == REG_K1);
   endfunction

endpackage

// File: rtl/regarb_starve_ctr.sv
// Starvation guard for the ALU writeback source.
// Counts consecutive cycles in which the ALU asks for the write port but is
// refused. Once the count has reached STARVE_LIMIT the FSM moves to
// FORCE_ALU, which flips the general-port priority towards the ALU until
// the ALU is accepted or withdraws its request.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   alu_valid  in  ALU write request
//   alu_ready  in  ALU request accepted this cycle
//   force_alu  out registered; high while in FORCE_ALU
module regarb_starve_ctr
   import regarb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic alu_valid,
   input  logic alu_ready,
   output logic force_alu
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] CTR_MAX = CW'(STARVE_LIMIT);

   state_t        state;
   logic [CW-1:0] wait_ctr;

   // The transition to FORCE_ALU looks at the registered count, so the
   // forced grant lands one cycle after the count saturates. A limit of
   // zero keeps the counter pinned at zero and never forces.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_NORMAL;
         wait_ctr  <= '0;
         force_alu <= 1'b0;
      end else if (!alu_valid || alu_ready) begin
         state     <= ST_NORMAL;
         wait_ctr  <= '0;
         force_alu <= 1'b0;
      end else begin
         if (wait_ctr != CTR_MAX) begin
            wait_ctr <= wait_ctr + 1'b1;
         end
         if ((STARVE_LIMIT != 0) && (wait_ctr == CTR_MAX)) begin
            state     <= ST_FORCE_ALU;
            force_alu <= 1'b1;
         end else begin
            force_alu <= (state == ST_FORCE_ALU);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single general write port between the
// ALU and MEM writeback sources, and drives the separate jal/return_address
// link port. Writes to $0/$26/$27 are accepted but dropped; general writes
// to $31 are redirected onto the link port. All register-file outputs are
// registered so they are stable before the register file's negedge write.
// Optional feature macro: REGARB_FAULT_EN (protected-write fault counter).
// Ports:
//   Clk, Rst                      clock, asynchronous active-high reset
//   alu_valid/addr/data, alu_ready   ALU writeback request channel
//   mem_valid/addr/data, mem_ready   MEM (load) writeback request channel
//   link_valid, link_ra, link_ready  jal link request channel
//   WAddr, WData, RegWrite          general write port to register file
//   jal, return_address             link write port to register file
//   fault_sticky, fault_count       protected-write faults (REGARB_FAULT_EN)
module regfile_wb_arbiter
   import regarb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int FAULT_W      = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               alu_valid,
   output logic               alu_ready,
   input  logic [4:0]         alu_addr,
   input  logic [31:0]        alu_data,
   input  logic               mem_valid,
   output logic               mem_ready,
   input  logic [4:0]         mem_addr,
   input  logic [31:0]        mem_data,
   input  logic               link_valid,
   input  logic [31:0]        link_ra,
   output logic               link_ready,
   output logic [4:0]         WAddr,
   output logic [31:0]        WData,
   output logic               RegWrite,
   output logic               jal,
   output logic [31:0]        return_address
`ifdef REGARB_FAULT_EN
   ,
   output logic               fault_sticky,
   output logic [FAULT_W-1:0] fault_count
`endif
);

   logic        force_alu;
   logic        alu_ok;
   logic        mem_ok;
   src_t        grant_src;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;
   logic        sel_is_ra;
   logic        sel_drop;

   regarb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk       (Clk),
      .rst       (Rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .force_alu (force_alu)
   );

   // A $31 general write needs the link port, so it cannot go while a real
   // link request owns that port.
   assign alu_ok = !((alu_addr == REG_RA) && link_valid);
   assign mem_ok = !((mem_addr == REG_RA) && link_valid);

   // Each ready depends only on the other source's valid, never its own.
   // The favoured source takes the port whenever it is eligible; the other
   // one gets it only when the favoured one is idle or blocked by a link.
   always_comb begin
      alu_ready  = 1'b0;
      mem_ready  = 1'b0;
      link_ready = 1'b0;
      if (!Rst) begin
         link_ready = 1'b1;
         if (force_alu) begin
            alu_ready = alu_ok;
            mem_ready = mem_ok && !(alu_valid && alu_ok);
         end else begin
            mem_ready = mem_ok;
            alu_ready = alu_ok && !(mem_valid && mem_ok);
         end
      end
   end

   // Pick the accepted general source and classify its destination.
   always_comb begin
      grant_src = SRC_NONE;
      sel_addr  = '0;
      sel_data  = '0;
      if (alu_valid && alu_ready) begin
         grant_src = SRC_ALU;
         sel_addr  = alu_addr;
         sel_data  = alu_data;
      end else if (mem_valid && mem_ready) begin
         grant_src = SRC_MEM;
         sel_addr  = mem_addr;
         sel_data  = mem_data;
      end
      sel_is_ra = (grant_src != SRC_NONE) && (sel_addr == REG_RA);
      sel_drop  = (grant_src != SRC_NONE) && is_protected(sel_addr);
   end

   // Output registers: every accepted write shows up for exactly the next
   // cycle. Address/data hold their last value when no write is pulsing.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         WAddr          <= '0;
         WData          <= '0;
         RegWrite       <= 1'b0;
         jal            <= 1'b0;
         return_address <= '0;
      end else begin
         if (link_valid) begin
            jal            <= 1'b1;
            return_address <= link_ra;
         end else if (sel_is_ra) begin
            jal            <= 1'b1;
            return_address <= sel_data;
         end else begin
            jal            <= 1'b0;
         end
         if ((grant_src != SRC_NONE) && !sel_is_ra && !sel_drop) begin
            RegWrite <= 1'b1;
            WAddr    <= sel_addr;
            WData    <= sel_data;
         end else begin
            RegWrite <= 1'b0;
         end
      end
   end

`ifdef REGARB_FAULT_EN
   // Every dropped protected write is recorded; only reset clears it.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fault_sticky <= 1'b0;
         fault_count  <= '0;
      end else if (sel_drop) begin
         fault_sticky <= 1'b1;
         if (fault_count != {FAULT_W{1'b1}}) begin
            fault_count <= fault_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (STARVE_LIMIT=4).
// Inputs change on the negedge; readies are sampled 1 ns later and the
// registered outputs 1 ns after the following posedge.
module tb_regfile_wb_arbiter;

   logic        Clk;
   logic        Rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_addr;
   logic [31:0] mem_data;
   logic        link_valid;
   logic [31:0] link_ra;
   logic        link_ready;
   logic [4:0]  WAddr;
   logic [31:0] WData;
   logic        RegWrite;
   logic        jal;
   logic [31:0] return_address;
`ifdef REGARB_FAULT_EN
   logic        fault_sticky;
   logic [7:0]  fault_count;
`endif

   int testsRun  = 0;
   int testsFail = 0;

   regfile_wb_arbiter #(
      .STARVE_LIMIT(4),
      .FAULT_W     (8)
   ) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_addr       (alu_addr),
      .alu_data       (alu_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .link_valid     (link_valid),
      .link_ra        (link_ra),
      .link_ready     (link_ready),
      .WAddr          (WAddr),
      .WData          (WData),
      .RegWrite       (RegWrite),
      .jal            (jal),
      .return_address (return_address)
`ifdef REGARB_FAULT_EN
      ,
      .fault_sticky   (fault_sticky),
      .fault_count    (fault_count)
`endif
   );

   // 10 ns clock, posedges at 5, 15, 25, ...
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic lv, input logic [31:0] lr);
      alu_valid  = av;
      alu_addr   = aa;
      alu_data   = ad;
      mem_valid  = mv;
      mem_addr   = ma;
      mem_data   = md;
      link_valid = lv;
      link_ra    = lr;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 32'h99);
      repeat (2) @(negedge Clk);
      #1;
      testsRun++;
      if ({RegWrite, jal, WAddr, WData, return_address} !== 71'd0) begin
         testsFail++;
         $display("[TB] FAIL reset_outputs: got RegWrite=%0b jal=%0b WAddr=%0d WData=%h ra=%h, want all 0",
                  RegWrite, jal, WAddr, WData, return_address);
      end
      testsRun++;
      if ({alu_ready, mem_ready, link_ready} !== 3'b000) begin
         testsFail++;
         $display("[TB] FAIL reset_readies: got %b, want 000", {alu_ready, mem_ready, link_ready});
      end
      // Release, launch a write, then reset again while it is on the outputs.
      @(negedge Clk);
      Rst = 1'b0;
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(posedge Clk);
      #1;
      testsRun++;
      if (RegWrite !== 1'b1 || WAddr !== 5'd3) begin
         testsFail++;
         $display("[TB] FAIL pre_reset_write: got RegWrite=%0b WAddr=%0d, want 1/3", RegWrite, WAddr);
      end
      #1 Rst = 1'b1;
      #1;
      testsRun++;
      if ({RegWrite, WAddr, WData} !== 38'd0 || {alu_ready, link_ready} !== 2'b00) begin
         testsFail++;
         $display("[TB] FAIL mid_write_reset: got RegWrite=%0b WAddr=%0d WData=%h readies=%b, want 0",
                  RegWrite, WAddr, WData, {alu_ready, link_ready});
      end
      @(negedge Clk);
      Rst = 1'b0;
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 32'h0);
      #1;
      testsRun++;
      if ({alu_ready, mem_ready, link_ready} !== 3'b011) begin
         testsFail++;
         $display("[TB] FAIL post_reset_normal: got alu/mem/link ready=%b, want 011",
                  {alu_ready, mem_ready, link_ready});
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(negedge Clk);
   endtask

   task automatic test_single_alu();
      @(negedge Clk);
      applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      #1;
      testsRun++;
      if (alu_ready !== 1'b1) begin
         testsFail++;
         $display("[TB] FAIL alu_alone_ready: got %0b, want 1", alu_ready);
      end
      @(posedge Clk);
      #1;
      testsRun++;
      if (RegWrite !== 1'b1 || WAddr !== 5'd5 || WData !== 32'h1234) begin
         testsFail++;
         $display("[TB] FAIL alu_alone_write: got RegWrite=%0b WAddr=%0d WData=%h, want 1/5/1234",
                  RegWrite, WAddr, WData);
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(posedge Clk);
      #1;
      testsRun++;
      if (RegWrite !== 1'b0) begin
         testsFail++;
         $display("[TB] FAIL alu_alone_pulse: got RegWrite=%0b, want 0", RegWrite);
      end
   endtask

   task automatic test_priority();
      @(negedge Clk);
      applyStimulus(1'b1, 5'd8, 32'hA, 1'b1, 5'd9, 32'hB, 1'b0, 32'h0);
      #1;
      testsRun++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
         testsFail++;
         $display("[TB] FAIL prio_readies: got alu=%0b mem=%0b, want 0/1", alu_ready, mem_ready);
      end
      @(posedge Clk);
      #1;
      testsRun++;
      if (RegWrite !== 1'b1 || WAddr !== 5'd9 || WData !== 32'hB) begin
         testsFail++;
         $display("[TB] FAIL prio_mem_first: got RegWrite=%0b WAddr=%0d WData=%h, want 1/9/B",
                  RegWrite, WAddr, WData);
      end
      @(negedge Clk);
      mem_valid = 1'b0;
      @(posedge Clk);
      #1;
      testsRun++;
      if (RegWrite !== 1'b1 || WAddr !== 5'd8 || WData !== 32'hA) begin
         testsFail++;
         $display("[TB] FAIL prio_alu_second: got RegWrite=%0b WAddr=%0d WData=%h, want 1/8/A",
                  RegWrite, WAddr, WData);
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(negedge Clk);
   endtask

   task automatic test_starvation();
      logic       expAlu;
      logic [4:0] expAddr;
      @(negedge Clk);
      applyStimulus(1'b1, 5'd8, 32'hA, 1'b1, 5'd9, 32'hB, 1'b0, 32'h0);
      // Cycles 0-4 stall the ALU, cycle 5 forces it, cycle 6 is back to NORMAL.
      for (int c = 0; c < 7; c++) begin
         expAlu  = (c == 5);
         expAddr = expAlu ? 5'd8 : 5'd9;
         #1;
         testsRun++;
         if (alu_ready !== expAlu || mem_ready !== !expAlu) begin
            testsFail++;
            $display("[TB] FAIL starve_ready_c%0d: got alu=%0b mem=%0b, want %0b/%0b",
                     c, alu_ready, mem_ready, expAlu, !expAlu);
         end
         @(posedge Clk);
         #1;
         testsRun++;
         if (RegWrite !== 1'b1 || WAddr !== expAddr) begin
            testsFail++;
            $display("[TB] FAIL starve_write_c%0d: got RegWrite=%0b WAddr=%0d, want 1/%0d",
                     c, RegWrite, WAddr, expAddr);
         end
         @(negedge Clk);
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(negedge Clk);
   endtask

   task automatic test_link_conflict();
      @(negedge Clk);
      applyStimulus(1'b1, 5'd31, 32'h800, 1'b0, 5'd0, 32'h0, 1'b1, 32'h400);
      #1;
      testsRun++;
      if (alu_ready !== 1'b0 || link_ready !== 1'b1) begin
         testsFail++;
         $display("[TB] FAIL link_conflict_ready: got alu=%0b link=%0b, want 0/1", alu_ready, link_ready);
      end
      @(posedge Clk);
      #1;
      testsRun++;
      if (jal !== 1'b1 || return_address !== 32'h400 || RegWrite !== 1'b0) begin
         testsFail++;
         $display("[TB] FAIL link_first: got jal=%0b ra=%h RegWrite=%0b, want 1/400/0",
                  jal, return_address, RegWrite);
      end
      @(negedge Clk);
      link_valid = 1'b0;
      @(posedge Clk);
      #1;
      testsRun++;
      if (jal !== 1'b1 || return_address !== 32'h800 || RegWrite !== 1'b0) begin
         testsFail++;
         $display("[TB] FAIL ra_redirect: got jal=%0b ra=%h RegWrite=%0b, want 1/800/0",
                  jal, return_address, RegWrite);
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(posedge Clk);
      #1;
      testsRun++;
      if (jal !== 1'b0) begin
         testsFail++;
         $display("[TB] FAIL jal_pulse: got jal=%0b, want 0", jal);
      end
   endtask

   task automatic test_back_to_back_link();
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b1, 32'h500);
      @(posedge Clk);
      #1;
      testsRun++;
      if (jal !== 1'b1 || return_address !== 32'h500 || RegWrite !== 1'b1 ||
          WAddr !== 5'd7 || WData !== 32'h77) begin
         testsFail++;
         $display("[TB] FAIL link_parallel: got jal=%0b ra=%h RegWrite=%0b WAddr=%0d WData=%h, want 1/500/1/7/77",
                  jal, return_address, RegWrite, WAddr, WData);
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(negedge Clk);
   endtask

   task automatic test_protected();
      @(negedge Clk);
      applyStimulus(1'b1, 5'd26, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      #1;
      testsRun++;
      if (alu_ready !== 1'b1) begin
         testsFail++;
         $display("[TB] FAIL prot_k0_ready: got %0b, want 1", alu_ready);
      end
      @(posedge Clk);
      #1;
      testsRun++;
      if (RegWrite !== 1'b0) begin
         testsFail++;
         $display("[TB] FAIL prot_k0_drop: got RegWrite=%0b, want 0", RegWrite);
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1, 1'b0, 32'h0);
      #1;
      testsRun++;
      if (mem_ready !== 1'b1) begin
         testsFail++;
         $display("[TB] FAIL prot_zero_ready: got %0b, want 1", mem_ready);
      end
      @(posedge Clk);
      #1;
      testsRun++;
      if (RegWrite !== 1'b0) begin
         testsFail++;
         $display("[TB] FAIL prot_zero_drop: got RegWrite=%0b, want 0", RegWrite);
      end
      @(negedge Clk);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      @(negedge Clk);
`ifdef REGARB_FAULT_EN
      testsRun++;
      if (fault_count !== 8'd2 || fault_sticky !== 1'b1) begin
         testsFail++;
         $display("[TB] FAIL fault_counter: got count=%0d sticky=%0b, want 2/1", fault_count, fault_sticky);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_priority();
      test_starvation();
      test_link_conflict();
      test_back_to_back_link();
      test_protected();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
